uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART transmitter (tx_start/tx_data/tx_busy handshake) among N_REQ byte-stream requesters.
- Grant is held for a whole packet, so packets from different requesters never interleave on the serial line.
- A packet ends on the byte flagged last.
- Sits between on-chip producers (debug console, telemetry, command replies) and the UART transmit side.

---
 rtl/uart_tx_arbiter.sv | 156 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter among N_REQ byte-stream requesters.
// Ownership is granted round-robin and held for a whole packet, so packets
// from different requesters never interleave on the serial line. A granted
// requester that stalls mid-packet for HOLD_TIMEOUT cycles loses its grant.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int HOLD_TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     grant,
  output logic                 uart_tx_start,
  output logic [7:0]           uart_tx_data,
  input  logic                 uart_tx_busy,
  output logic                 timeout_err
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(HOLD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [N_REQ-1:0]   r_grant;
  logic               r_tx_start;
  logic [7:0]         r_tx_data;
  logic               r_timeout_err;
  logic               r_last_q;
  logic [CNT_W-1:0]   r_hold_cnt;

  logic [2*N_REQ-1:0] w_vld_dbl;
  logic [N_REQ-1:0]   w_vld_rot;
  logic [N_REQ-1:0]   w_pick_rot;
  logic [2*N_REQ-1:0] w_pick_dbl;
  logic [N_REQ-1:0]   w_rr_sel;
  logic [PTR_W-1:0]   w_owner;
  logic [PTR_W-1:0]   w_owner_next;
  logic [7:0]         w_owner_data;
  logic               w_owner_last;
  logic               w_owner_valid;
  logic               w_accept;
  logic [CNT_W-1:0]   w_hold_inc;

  // Round-robin pick: rotate requests so rr_ptr sits at bit 0, isolate the
  // lowest set bit, then rotate the one-hot result back into place.
  assign w_vld_dbl  = {req_valid, req_valid} >> r_rr_ptr;
  assign w_vld_rot  = w_vld_dbl[N_REQ-1:0];
  assign w_pick_rot = w_vld_rot & (~w_vld_rot + N_REQ'(1));
  assign w_pick_dbl = {w_pick_rot, w_pick_rot} << r_rr_ptr;
  assign w_rr_sel   = w_pick_dbl[2*N_REQ-1:N_REQ];

  // Decode the current owner's index, byte and last flag from the one-hot grant.
  always_comb begin
    w_owner      = '0;
    w_owner_data = 8'h00;
    w_owner_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant[i]) begin
        w_owner      = PTR_W'(i);
        w_owner_data = req_data[8*i +: 8];
        w_owner_last = req_last[i];
      end
    end
  end

  assign w_owner_next  = (w_owner == PTR_W'(N_REQ - 1)) ? '0 : w_owner + PTR_W'(1);
  assign w_owner_valid = |(r_grant & req_valid);
  assign w_accept      = (r_state == S_GRANT) && w_owner_valid && !uart_tx_busy;
  assign w_hold_inc    = (r_hold_cnt == CNT_MAX) ? r_hold_cnt : r_hold_cnt + CNT_W'(1);

  // Accept strobe goes only to the owner, and only while the transmitter is free.
  assign req_ready = w_accept ? (r_grant & req_valid) : '0;

  // Arbitration and transmit handshake FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_grant       <= '0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= 8'h00;
      r_timeout_err <= 1'b0;
      r_last_q      <= 1'b0;
      r_hold_cnt    <= '0;
    end else begin
      r_tx_start    <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|req_valid) begin
            r_grant <= w_rr_sel;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (w_accept) begin
            // Accept wins over a timeout reached in the same cycle.
            r_tx_data  <= w_owner_data;
            r_last_q   <= w_owner_last;
            r_hold_cnt <= '0;
            r_tx_start <= 1'b1;
            r_state    <= S_START;
          end else if (w_hold_inc == HOLD_LIM) begin
            r_timeout_err <= 1'b1;
            r_grant       <= '0;
            r_rr_ptr      <= w_owner_next;
            r_hold_cnt    <= '0;
            r_state       <= S_IDLE;
          end else begin
            r_hold_cnt <= w_hold_inc;
          end
        end
        S_START: begin
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (uart_tx_busy) r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (!uart_tx_busy) begin
            if (r_last_q) begin
              r_grant  <= '0;
              r_rr_ptr <= w_owner_next;
              r_state  <= S_IDLE;
            end else begin
              r_state <= S_GRANT;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign grant         = r_grant;
  assign uart_tx_start = r_tx_start;
  assign uart_tx_data  = r_tx_data;
  assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: byte-queue requesters, a simple
// UART busy model, a packet-level round-robin reference and per-cycle checks.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int HT   = 5;
  localparam int BLEN = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_valid;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     req_last;
  logic [N-1:0]     req_ready;
  logic [N-1:0]     grant;
  logic             uart_tx_start;
  logic [7:0]       uart_tx_data;
  logic             uart_tx_busy;
  logic             timeout_err;

  uart_tx_arbiter #(.N_REQ(N), .HOLD_TIMEOUT(HT)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .grant         (grant),
    .uart_tx_start (uart_tx_start),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_busy  (uart_tx_busy),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Requester byte buffers: bit 8 is the last flag.
  logic [8:0] rbuf [N][8];
  int         rhead [N];
  int         rtail [N];
  logic [N-1:0] en;

  // UART busy model state.
  int busy_dly, bz_wait, bz_left;

  // Reference: expected (owner, byte) per tx_start, in order.
  int         exp_own[$];
  logic [7:0] exp_byte[$];
  int         m_ptr;

  int start_own[$];
  int start_cyc[$];

  logic [7:0]   prev_data;
  logic         prev_acc;
  logic [7:0]   acc_byte;
  logic         prev_busy;
  int           busy_fall_cyc, tcount, rcount;
  logic [N-1:0] s_grant, s_ready;
  logic         s_start, s_terr;
  logic [7:0]   s_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int i, input logic [7:0] b, input logic last);
    rbuf[i][rtail[i]] = {last, b};
    rtail[i]++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (en[i] && rhead[i] < rtail[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = rbuf[i][rhead[i]][7:0];
        req_last[i]        = rbuf[i][rhead[i]][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  // Packet-level round robin: from the pointer, the first requester with a
  // pending packet sends all of it, then the pointer moves past it.
  task automatic model_plan();
    int h [N];
    int g, idx;
    logic [8:0] b;
    bit go;
    for (int i = 0; i < N; i++) h[i] = rhead[i];
    go = 1'b1;
    while (go) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && en[idx] && h[idx] < rtail[idx]) g = idx;
      end
      if (g < 0) begin
        go = 1'b0;
      end else begin
        b = 9'h100;
        b[8] = 1'b0;
        while (!b[8] && h[g] < rtail[g]) begin
          b = rbuf[g][h[g]];
          h[g]++;
          exp_own.push_back(g);
          exp_byte.push_back(b[7:0]);
        end
        m_ptr = (g + 1) % N;
      end
    end
  endtask

  // Per-cycle comparison against the reference and the handshake rules.
  task automatic compare();
    int own;
    s_grant = grant;
    s_ready = req_ready;
    s_start = uart_tx_start;
    s_terr  = timeout_err;
    s_data  = uart_tx_data;
    if (reset) begin
      prev_data = uart_tx_data;
      prev_acc  = 1'b0;
      prev_busy = uart_tx_busy;
      return;
    end
    chk("grant_onehot0", 32'($onehot0(grant)), 1);
    chk("ready_onehot0", 32'($onehot0(req_ready)), 1);
    chk("ready_within_owner", 32'((req_ready & ~(grant & req_valid)) == '0), 1);
    if (prev_acc) chk("data_captured", uart_tx_data, acc_byte);
    else          chk("data_stable", uart_tx_data, prev_data);
    if (uart_tx_start) begin
      chk("start_while_idle_uart", uart_tx_busy, 0);
      own = -1;
      for (int i = 0; i < N; i++) if (grant[i]) own = i;
      start_own.push_back(own);
      start_cyc.push_back(cyc);
      checks++;
      if (exp_own.size() == 0) begin
        errors++;
        $display("FAIL unexpected_start: got start with data %0h owner %0d, expected no start (cycle %0d)",
                 uart_tx_data, own, cyc);
      end else begin
        chk("tx_byte", uart_tx_data, exp_byte[0]);
        chk("tx_owner", own, exp_own[0]);
        void'(exp_own.pop_front());
        void'(exp_byte.pop_front());
      end
    end
    if (timeout_err) tcount++;
    if (prev_busy && !uart_tx_busy) busy_fall_cyc = cyc;
    rcount   += $countones(req_ready);
    prev_acc  = |req_ready;
    for (int i = 0; i < N; i++) if (req_ready[i]) acc_byte = req_data[8*i +: 8];
    prev_data = uart_tx_data;
    prev_busy = uart_tx_busy;
  endtask

  task automatic step();
    logic [N-1:0] rdy;
    logic st;
    @(negedge clk);
    cyc++;
    compare();
    rdy = req_ready;
    st  = uart_tx_start;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (rdy[i] && rhead[i] < rtail[i]) rhead[i]++;
    if (st) bz_wait = busy_dly;
    if (bz_wait > 0) begin
      bz_wait--;
      if (bz_wait == 0) begin
        uart_tx_busy = 1'b1;
        bz_left      = BLEN;
      end
    end else if (uart_tx_busy) begin
      bz_left--;
      if (bz_left == 0) uart_tx_busy = 1'b0;
    end
    drive();
  endtask

  task automatic clear_stim();
    for (int i = 0; i < N; i++) begin
      rhead[i] = 0;
      rtail[i] = 0;
    end
    en           = '0;
    bz_wait      = 0;
    bz_left      = 0;
    uart_tx_busy = 1'b0;
    exp_own.delete();
    exp_byte.delete();
    start_own.delete();
    start_cyc.delete();
    rcount = 0;
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_stim();
    m_ptr = 0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic run_done(input string name);
    int n;
    n = 0;
    while ((exp_own.size() != 0 || grant != '0 || uart_tx_busy || bz_wait != 0) && n < 400) begin
      step();
      n++;
    end
    chk({name, "_finished_in_budget"}, 32'(n < 400), 1);
    chk({name, "_all_bytes_sent"}, exp_own.size(), 0);
    for (int k = 0; k < 3; k++) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s2_ord [4] = '{0, 0, 2, 2};
    int s3_ord [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int gap, t0, sc0, n;

    reset        = 1'b1;
    req_valid    = '0;
    req_data     = '0;
    req_last     = '0;
    uart_tx_busy = 1'b0;
    busy_dly     = 1;
    prev_data    = 8'h00;
    prev_acc     = 1'b0;
    prev_busy    = 1'b0;
    acc_byte     = 8'h00;
    busy_fall_cyc = 0;
    tcount       = 0;
    rcount       = 0;
    m_ptr        = 0;
    clear_stim();
    #1;

    // Reset values
    step();
    chk("rst_grant", s_grant, 0);
    chk("rst_start", s_start, 0);
    chk("rst_data", s_data, 0);
    chk("rst_timeout_err", s_terr, 0);
    chk("rst_ready", s_ready, 0);
    reset = 1'b0;
    step();

    // Single requester 1, two-byte packet
    push(1, 8'h41, 1'b0);
    push(1, 8'h42, 1'b1);
    en = 4'b0010;
    model_plan();
    drive();
    step();
    chk("s1_grant_same_cycle", s_grant, 4'b0000);
    step();
    chk("s1_grant_next_cycle", s_grant, 4'b0010);
    chk("s1_ready_first", s_ready, 4'b0010);
    run_done("s1");
    chk("s1_start_count", start_own.size(), 2);
    chk("s1_ready_pulses", rcount, 2);
    gap = (start_cyc.size() >= 2) ? start_cyc[1] - start_cyc[0] : -1;
    chk("s1_start_gap", gap, BLEN + 3);

    // rr_ptr is now 2: requesters 0 and 2 together must go 2 first
    start_own.delete();
    start_cyc.delete();
    push(0, 8'h50, 1'b1);
    push(2, 8'h52, 1'b1);
    en = 4'b0101;
    model_plan();
    drive();
    step();
    step();
    chk("s1b_grant_from_ptr2", s_grant, 4'b0100);
    run_done("s1b");
    chk("s1b_first_owner", (start_own.size() > 0) ? start_own[0] : -1, 2);

    // Two simultaneous two-byte packets, no interleaving
    do_reset();
    push(0, 8'hA0, 1'b0);
    push(0, 8'hA1, 1'b1);
    push(2, 8'hC0, 1'b0);
    push(2, 8'hC1, 1'b1);
    en = 4'b0101;
    model_plan();
    drive();
    run_done("s2");
    chk("s2_start_count", start_own.size(), 4);
    for (int k = 0; k < 4; k++)
      chk("s2_order", (start_own.size() > k) ? start_own[k] : -1, s2_ord[k]);

    // Fairness: all four with back-to-back single-byte packets
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push(i, 8'(8'h60 + 16 * r + i), 1'b1);
    en = 4'b1111;
    model_plan();
    drive();
    run_done("s3");
    chk("s3_start_count", start_own.size(), 8);
    for (int k = 0; k < 8; k++)
      chk("s3_grant_seq", (start_own.size() > k) ? start_own[k] : -1, s3_ord[k]);

    // Timeout: req3 sends one non-last byte then goes quiet; req0 waits
    do_reset();
    t0 = tcount;
    push(3, 8'h10, 1'b0);
    push(0, 8'h20, 1'b1);
    en = 4'b1000;
    exp_own.push_back(3);
    exp_byte.push_back(8'h10);
    exp_own.push_back(0);
    exp_byte.push_back(8'h20);
    drive();
    n = 0;
    while (s_grant != 4'b1000 && n < 20) begin
      step();
      n++;
    end
    chk("s4_req3_granted", s_grant, 4'b1000);
    en = 4'b1001;
    drive();
    n = 0;
    while (!s_terr && n < 100) begin
      step();
      n++;
    end
    chk("s4_timeout_seen", s_terr, 1);
    // One WAIT_DONE cycle sees busy low, then five GRANT cycles expire.
    chk("s4_timeout_delay", cyc - busy_fall_cyc, 6);
    chk("s4_grant_cleared", s_grant, 0);
    step();
    chk("s4_req0_next", s_grant, 4'b0001);
    chk("s4_single_pulse", tcount - t0, 1);
    run_done("s4");
    chk("s4_total_pulses", tcount - t0, 1);

    // Slow transmitter raising busy 3 cycles after start
    do_reset();
    busy_dly = 3;
    push(1, 8'h31, 1'b0);
    push(1, 8'h32, 1'b1);
    en = 4'b0010;
    model_plan();
    drive();
    run_done("s5");
    chk("s5_start_count", start_own.size(), 2);
    gap = (start_cyc.size() >= 2) ? start_cyc[1] - start_cyc[0] : -1;
    chk("s5_start_gap", gap, BLEN + 5);
    busy_dly = 1;

    // Asynchronous reset while waiting for busy to fall
    do_reset();
    push(2, 8'h77, 1'b0);
    push(2, 8'h78, 1'b1);
    en = 4'b0100;
    model_plan();
    drive();
    n = 0;
    while (!s_start && n < 20) begin
      step();
      n++;
    end
    step();
    chk("s6_busy_before_reset", uart_tx_busy, 1);
    chk("s6_grant_before_reset", grant, 4'b0100);
    reset = 1'b1;
    #1;
    chk("s6_async_grant", grant, 0);
    chk("s6_async_start", uart_tx_start, 0);
    chk("s6_async_data", uart_tx_data, 0);
    clear_stim();
    sc0 = start_own.size();
    step();
    step();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk("s6_no_start_after_reset", start_own.size() - sc0, 0);
    chk("s6_idle_grant", s_grant, 0);
    chk("total_timeout_pulses", tcount, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
